plab2_proc_mem_arbiter: RTL and testbench

PLAB2_PROC_MEM_ARBITER -- requirements
Module: plab2_proc_MemArbiter

---
 rtl/plab2_proc_mem_arbiter.sv | 87 ++++++++
 tb/tb_plab2_proc_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plab2_proc_mem_arbiter.sv
// plab2_proc_mem_arbiter: merges imem/dmem request streams into one memory port and routes responses back; define PLAB2_PROC_MEM_ARB_RR_EN for round-robin, otherwise fixed dmem-over-imem priority
module plab2_proc_mem_arbiter #(
  parameter int p_max_outs = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [76:0] imemreq_msg,
  input  logic        imemreq_val,
  output logic        imemreq_rdy,
  input  logic [76:0] dmemreq_msg,
  input  logic        dmemreq_val,
  output logic        dmemreq_rdy,
  output logic [76:0] memreq_msg,
  output logic        memreq_val,
  input  logic        memreq_rdy,
  input  logic [46:0] memresp_msg,
  input  logic        memresp_val,
  output logic        memresp_rdy,
  output logic [46:0] imemresp_msg,
  output logic        imemresp_val,
  input  logic        imemresp_rdy,
  output logic [46:0] dmemresp_msg,
  output logic        dmemresp_val,
  input  logic        dmemresp_rdy,
  input  logic        sd
);
  localparam logic PREF_I = 1'b0;
  localparam logic PREF_D = 1'b1;
  localparam logic [2:0] max_c = 3'(p_max_outs);
  logic [2:0] i_cnt, d_cnt;
  logic state, state_n, val_q, live, pref_d;
  logic [76:0] msg_q;
  logic i_elig, d_elig, can_acc, grant;
  logic go, src, i_drop, d_drop, i_dec, d_dec;
  logic [46:0] resp_msg;
  logic [2:0] unused_bits;
  assign unused_bits = {sd, imemreq_msg[73], dmemreq_msg[73]};
  assign i_elig = imemreq_val && i_cnt != max_c;
  assign d_elig = dmemreq_val && d_cnt != max_c;
  assign can_acc = reset && (!val_q || memreq_rdy);
`ifdef PLAB2_PROC_MEM_ARB_RR_EN
  assign pref_d = state == PREF_D;
  assign state_n = (can_acc && i_elig && d_elig) ? ~state : state;
`else
  logic unused_state;
  assign unused_state = state;
  assign pref_d = 1'b1;
  assign state_n = PREF_I;
`endif
  assign imemreq_rdy = can_acc && i_elig && (!d_elig || !pref_d);
  assign dmemreq_rdy = can_acc && d_elig && (!i_elig || pref_d);
  assign grant = imemreq_rdy || dmemreq_rdy;
  assign memreq_val = reset && val_q;
  assign memreq_msg = msg_q;
  assign go = reset && live;
  assign src = memresp_msg[43];
  assign i_drop = !go || i_cnt == 3'd0;
  assign d_drop = !go || d_cnt == 3'd0;
  assign resp_msg = {memresp_msg[46:44], 1'b0, memresp_msg[42:0]};
  assign imemresp_msg = resp_msg;
  assign dmemresp_msg = resp_msg;
  assign imemresp_val = memresp_val && !src && !i_drop;
  assign dmemresp_val = memresp_val && src && !d_drop;
  assign memresp_rdy = src ? (d_drop || dmemresp_rdy) : (i_drop || imemresp_rdy);
  assign i_dec = imemresp_val && imemresp_rdy;
  assign d_dec = dmemresp_val && dmemresp_rdy;
  // control state: pipe valid, per-source outstanding counters, arbitration preference
  always_ff @(posedge clk)
    if (!reset) begin
      val_q <= 1'b0;
      i_cnt <= 3'd0;
      d_cnt <= 3'd0;
      state <= PREF_I;
    end else begin
      val_q <= grant || (val_q && !memreq_rdy);
      i_cnt <= i_cnt + 3'(imemreq_rdy) - 3'(i_dec);
      d_cnt <= d_cnt + 3'(dmemreq_rdy) - 3'(d_dec);
      state <= state_n;
    end
  // pipe payload with the source tag folded into opaque[7]; held while stalled
  always_ff @(posedge clk)
    if (grant) msg_q <= dmemreq_rdy ? {dmemreq_msg[76:74], 1'b1, dmemreq_msg[72:0]}
                                    : {imemreq_msg[76:74], 1'b0, imemreq_msg[72:0]};
  // low for the first cycle after reset so responses stay quiet then
  always_ff @(posedge clk)
    live <= reset;
endmodule

// File: tb/tb_plab2_proc_mem_arbiter.sv
// tb_plab2_proc_mem_arbiter: directed scoreboard bench for the memory arbiter
module tb_plab2_proc_mem_arbiter;
  logic clk, reset, sd;
  logic [76:0] imemreq_msg, dmemreq_msg, memreq_msg;
  logic imemreq_val, imemreq_rdy, dmemreq_val, dmemreq_rdy, memreq_val, memreq_rdy;
  logic [46:0] memresp_msg, imemresp_msg, dmemresp_msg;
  logic memresp_val, memresp_rdy, imemresp_val, imemresp_rdy, dmemresp_val, dmemresp_rdy;
  logic [76:0] req_q[$];
  logic [46:0] rsp_q[$];
  int checks = 0, errors = 0, i_out = 0, d_out = 0;
`ifdef PLAB2_PROC_MEM_ARB_RR_EN
  localparam bit rr = 1'b1;
`else
  localparam bit rr = 1'b0;
`endif

  plab2_proc_mem_arbiter #(.p_max_outs(4)) dut (
    .clk(clk), .reset(reset),
    .imemreq_msg(imemreq_msg), .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy),
    .dmemreq_msg(dmemreq_msg), .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy),
    .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
    .imemresp_msg(imemresp_msg), .imemresp_val(imemresp_val), .imemresp_rdy(imemresp_rdy),
    .dmemresp_msg(dmemresp_msg), .dmemresp_val(dmemresp_val), .dmemresp_rdy(dmemresp_rdy),
    .sd(sd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [76:0] mk_req(logic [2:0] t, logic [7:0] o, logic [31:0] a, logic [31:0] d);
    return {t, o, a, 2'b00, d};
  endfunction

  function automatic logic [46:0] mk_resp(logic [2:0] t, logic [7:0] o, logic [31:0] d);
    return {t, o, 4'b0000, d};
  endfunction

  task automatic chk(string tag, logic [76:0] obs, logic [76:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic chk_req(string tag);
    logic [76:0] e;
    e = (req_q.size() != 0) ? req_q.pop_front() : 'x;
    chk({tag, "_val"}, memreq_val, 1'b1);
    chk(tag, memreq_msg, e);
  endtask

  task automatic chk_iresp(string tag);
    logic [46:0] e;
    e = (rsp_q.size() != 0) ? rsp_q.pop_front() : 'x;
    chk({tag, "_val"}, imemresp_val, 1'b1);
    chk(tag, imemresp_msg, e);
  endtask

  task automatic chk_dresp(string tag);
    logic [46:0] e;
    e = (rsp_q.size() != 0) ? rsp_q.pop_front() : 'x;
    chk({tag, "_val"}, dmemresp_val, 1'b1);
    chk(tag, dmemresp_msg, e);
  endtask

  task automatic drain;
    for (int j = 0; d_out > 0; j++) begin
      memresp_val = 1'b1;
      memresp_msg = mk_resp(3'd0, 8'h80 | 8'(j), 32'(32'hD000 + j));
      rsp_q.push_back(mk_resp(3'd0, 8'(j), 32'(32'hD000 + j)));
      settle;
      chk_dresp("drain_d");
      chk("drain_d_noi", imemresp_val, 1'b0);
      next;
      d_out--;
    end
    for (int j = 0; i_out > 0; j++) begin
      memresp_val = 1'b1;
      memresp_msg = mk_resp(3'd0, 8'(j), 32'(32'hE000 + j));
      rsp_q.push_back(mk_resp(3'd0, 8'(j), 32'(32'hE000 + j)));
      settle;
      chk_iresp("drain_i");
      chk("drain_i_nod", dmemresp_val, 1'b0);
      next;
      i_out--;
    end
    memresp_val = 1'b0;
  endtask

  initial begin
    reset = 1'b0; sd = 1'b0;
    imemreq_msg = '0; dmemreq_msg = '0; memresp_msg = mk_resp(3'd0, 8'h00, 32'h1);
    imemreq_val = 1'b1; dmemreq_val = 1'b1; memresp_val = 1'b1;
    memreq_rdy = 1'b1; imemresp_rdy = 1'b1; dmemresp_rdy = 1'b1;
    next; settle;
    chk("rst_memreq_val", memreq_val, 1'b0);
    chk("rst_irdy", imemreq_rdy, 1'b0);
    chk("rst_drdy", dmemreq_rdy, 1'b0);
    chk("rst_iresp_val", imemresp_val, 1'b0);
    next;
    reset = 1'b1; imemreq_val = 1'b0; dmemreq_val = 1'b0;
    settle;
    chk("post_rst_memreq_val", memreq_val, 1'b0);
    chk("post_rst_iresp_val", imemresp_val, 1'b0);
    chk("post_rst_resp_rdy", memresp_rdy, 1'b1);
    next;
    memresp_val = 1'b0;
    // single imem read
    imemreq_val = 1'b1;
    imemreq_msg = mk_req(3'd0, 8'h00, 32'h200, 32'h0);
    req_q.push_back(mk_req(3'd0, 8'h00, 32'h200, 32'h0));
    settle;
    chk("single_i_irdy", imemreq_rdy, 1'b1);
    chk("single_i_drdy", dmemreq_rdy, 1'b0);
    chk("single_i_latency", memreq_val, 1'b0);
    next; i_out++;
    imemreq_val = 1'b0;
    settle;
    chk_req("single_i_req");
    next; settle;
    chk("single_i_empty", memreq_val, 1'b0);
    memresp_val = 1'b1;
    memresp_msg = mk_resp(3'd0, 8'h00, 32'hDEADBEEF);
    rsp_q.push_back(mk_resp(3'd0, 8'h00, 32'hDEADBEEF));
    settle;
    chk_iresp("single_i_resp");
    chk("single_i_resp_nod", dmemresp_val, 1'b0);
    chk("single_i_resp_rdy", memresp_rdy, 1'b1);
    next; i_out--;
    memresp_val = 1'b0;
    // single dmem write, opaque tagging both ways
    dmemreq_val = 1'b1;
    dmemreq_msg = mk_req(3'd1, 8'h05, 32'h1000, 32'hCAFEF00D);
    req_q.push_back(mk_req(3'd1, 8'h85, 32'h1000, 32'hCAFEF00D));
    settle;
    chk("single_d_drdy", dmemreq_rdy, 1'b1);
    next; d_out++;
    dmemreq_val = 1'b0;
    settle;
    chk_req("single_d_req");
    next;
    memresp_val = 1'b1;
    memresp_msg = mk_resp(3'd1, 8'h85, 32'h0);
    rsp_q.push_back(mk_resp(3'd1, 8'h05, 32'h0));
    settle;
    chk_dresp("single_d_resp");
    chk("single_d_resp_noi", imemresp_val, 1'b0);
    next; d_out--;
    memresp_val = 1'b0;
    // both sources valid for four cycles
    for (int k = 0; k < 4; k++) begin
      logic exp_d;
      imemreq_val = 1'b1; dmemreq_val = 1'b1;
      imemreq_msg = mk_req(3'd0, 8'h80 | 8'(k), 32'(32'h100 + k), 32'h0);
      dmemreq_msg = mk_req(3'd1, 8'h40 | 8'(k), 32'(32'h300 + k), 32'(k));
      exp_d = rr ? (k % 2 == 1) : 1'b1;
      settle;
      chk("arb_irdy", imemreq_rdy, !exp_d);
      chk("arb_drdy", dmemreq_rdy, exp_d);
      if (k > 0) chk_req("arb_req");
      if (exp_d) begin
        req_q.push_back(mk_req(3'd1, 8'hC0 | 8'(k), 32'(32'h300 + k), 32'(k)));
        d_out++;
      end else begin
        req_q.push_back(mk_req(3'd0, 8'(k), 32'(32'h100 + k), 32'h0));
        i_out++;
      end
      next;
    end
    imemreq_val = 1'b0; dmemreq_val = 1'b0;
    settle;
    chk_req("arb_last");
    next;
    drain;
    // dmem outstanding limit
    dmemreq_val = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dmemreq_msg = mk_req(3'd0, 8'(k), 32'(32'h400 + k), 32'h0);
      settle;
      chk("lim_drdy", dmemreq_rdy, 1'b1);
      if (k > 0) chk_req("lim_req");
      req_q.push_back(mk_req(3'd0, 8'h80 | 8'(k), 32'(32'h400 + k), 32'h0));
      d_out++;
      next;
    end
    dmemreq_msg = mk_req(3'd0, 8'h09, 32'h480, 32'h0);
    settle;
    chk("lim_full_drdy", dmemreq_rdy, 1'b0);
    chk_req("lim_req4");
    next;
    memresp_val = 1'b1;
    memresp_msg = mk_resp(3'd0, 8'h80, 32'h77);
    rsp_q.push_back(mk_resp(3'd0, 8'h00, 32'h77));
    settle;
    chk("lim_still_full", dmemreq_rdy, 1'b0);
    chk("lim_no_grant", memreq_val, 1'b0);
    chk_dresp("lim_resp");
    next; d_out--;
    memresp_val = 1'b0;
    settle;
    chk("lim_reopen", dmemreq_rdy, 1'b1);
    req_q.push_back(mk_req(3'd0, 8'h89, 32'h480, 32'h0));
    next; d_out++;
    dmemreq_val = 1'b0;
    settle;
    chk_req("lim_req5");
    next;
    // memory-side backpressure
    memreq_rdy = 1'b0;
    imemreq_val = 1'b1;
    imemreq_msg = mk_req(3'd0, 8'h21, 32'h500, 32'h0);
    req_q.push_back(mk_req(3'd0, 8'h21, 32'h500, 32'h0));
    settle;
    chk("bp_first_grant", imemreq_rdy, 1'b1);
    next; i_out++;
    imemreq_msg = mk_req(3'd0, 8'h22, 32'h504, 32'h0);
    for (int k = 0; k < 3; k++) begin
      settle;
      chk("bp_val", memreq_val, 1'b1);
      chk("bp_stable", memreq_msg, req_q[0]);
      chk("bp_no_grant", imemreq_rdy, 1'b0);
      next;
    end
    memreq_rdy = 1'b1;
    settle;
    chk_req("bp_fire");
    chk("bp_regrant", imemreq_rdy, 1'b1);
    req_q.push_back(mk_req(3'd0, 8'h22, 32'h504, 32'h0));
    next; i_out++;
    imemreq_val = 1'b0;
    settle;
    chk_req("bp_second");
    next;
    // response backpressure and simultaneous grant/response
    dmemresp_rdy = 1'b0;
    memresp_val = 1'b1;
    memresp_msg = mk_resp(3'd0, 8'h80, 32'h55);
    settle;
    chk("rbp_resp_rdy", memresp_rdy, 1'b0);
    chk("rbp_dval", dmemresp_val, 1'b1);
    next;
    dmemresp_rdy = 1'b1;
    rsp_q.push_back(mk_resp(3'd0, 8'h00, 32'h55));
    settle;
    chk_dresp("rbp_resp");
    next; d_out--;
    dmemreq_val = 1'b1;
    dmemreq_msg = mk_req(3'd0, 8'h31, 32'h600, 32'h0);
    memresp_msg = mk_resp(3'd0, 8'h81, 32'h66);
    rsp_q.push_back(mk_resp(3'd0, 8'h01, 32'h66));
    settle;
    chk("sim_drdy", dmemreq_rdy, 1'b1);
    chk_dresp("sim_resp");
    req_q.push_back(mk_req(3'd0, 8'hB1, 32'h600, 32'h0));
    next;
    memresp_val = 1'b0;
    dmemreq_msg = mk_req(3'd0, 8'h32, 32'h604, 32'h0);
    settle;
    chk("sim_cnt_below", dmemreq_rdy, 1'b1);
    chk_req("sim_req");
    req_q.push_back(mk_req(3'd0, 8'hB2, 32'h604, 32'h0));
    next; d_out++;
    settle;
    chk("sim_cnt_full", dmemreq_rdy, 1'b0);
    chk_req("sim_req2");
    next;
    dmemreq_val = 1'b0;
    drain;
    // response with no outstanding request is swallowed
    memresp_val = 1'b1;
    memresp_msg = mk_resp(3'd0, 8'h00, 32'h99);
    settle;
    chk("orphan_ival", imemresp_val, 1'b0);
    chk("orphan_rdy", memresp_rdy, 1'b1);
    next;
    memresp_val = 1'b0;
    // reset with a request held in the pipe
    memreq_rdy = 1'b0;
    imemreq_val = 1'b1;
    imemreq_msg = mk_req(3'd0, 8'h44, 32'h700, 32'h0);
    req_q.push_back(mk_req(3'd0, 8'h44, 32'h700, 32'h0));
    settle;
    chk("rst2_grant", imemreq_rdy, 1'b1);
    next;
    imemreq_val = 1'b0;
    settle;
    chk("rst2_held_val", memreq_val, 1'b1);
    chk("rst2_held", memreq_msg, req_q[0]);
    reset = 1'b0;
    settle;
    chk("rst2_gate", memreq_val, 1'b0);
    next;
    reset = 1'b1; memreq_rdy = 1'b1;
    req_q.delete();
    settle;
    chk("rst2_after1", memreq_val, 1'b0);
    next; settle;
    chk("rst2_discarded", memreq_val, 1'b0);
    memresp_val = 1'b1;
    memresp_msg = mk_resp(3'd0, 8'h44, 32'h1234);
    settle;
    chk("rst2_stray_ival", imemresp_val, 1'b0);
    chk("rst2_stray_rdy", memresp_rdy, 1'b1);
    next;
    memresp_val = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
